// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// mem_access_ctrl
// Sequences MEM-stage loads and stores onto a single-port data memory with one
// access outstanding. Word-crossing accesses are split into two aligned memory
// transactions. Load words are merged and extended. Store byte enables and write
// data are shifted onto the correct lanes.
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_type,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    // Access type encodings shared by the load and store datapaths.
    localparam logic [2:0] T_B  = 3'b000;  // LB / SB
    localparam logic [2:0] T_H  = 3'b001;  // LH / SH
    localparam logic [2:0] T_W  = 3'b010;  // LW / SW
    localparam logic [2:0] T_BU = 3'b011;  // LBU
    localparam logic [2:0] T_HU = 3'b100;  // LHU

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACC0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_ACC1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Captured request and returned read words.
    logic              we_q;
    logic              err_q;
    logic              split_q;
    logic [2:0]        type_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] word0_q;
    logic [DATA_W-1:0] word1_q;

    logic accept;
    logic req_illegal;
    logic req_split;

    // The controller only takes a new request while idle.
    assign accept = req_valid && (state_q == S_IDLE);

    // Classify the incoming request: illegal encodings and word-crossing accesses.
    always_comb begin
        req_illegal = req_we ? (req_type > T_W) : (req_type > T_HU);
        case (req_type)
            T_H, T_HU: req_split = (req_addr[1:0] == 2'b11);
            T_W:       req_split = (req_addr[1:0] != 2'b00);
            default:   req_split = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always updated with non-blocking assignments so
        // every register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture on accept, read-word capture while waiting for read data.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the datapath registers are reset as well so that a request abandoned
        // by reset can never leak stale lanes or read words into a later response.
        if (!rst_n) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            split_q <= 1'b0;
            type_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word0_q <= '0;
            word1_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                err_q   <= req_illegal;
                split_q <= req_split;
                type_q  <= req_type;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                word0_q <= '0;
                word1_q <= '0;
            end
            if (state_q == S_WAIT0 && mem_rvalid) begin
                word0_q <= mem_rdata;
            end
            if (state_q == S_WAIT1 && mem_rvalid) begin
                word1_q <= mem_rdata;
            end
        end
    end

    // Next-state logic; rvalid is only observed in the two WAIT states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = req_illegal ? S_RESP : S_ACC0;
                end
            end
            S_ACC0: begin
                if (mem_gnt) begin
                    if (we_q) begin
                        state_d = split_q ? S_ACC1 : S_RESP;
                    end else begin
                        state_d = S_WAIT0;
                    end
                end
            end
            S_WAIT0: begin
                if (mem_rvalid) begin
                    state_d = split_q ? S_ACC1 : S_RESP;
                end
            end
            S_ACC1: begin
                if (mem_gnt) begin
                    state_d = we_q ? S_RESP : S_WAIT1;
                end
            end
            S_WAIT1: begin
                if (mem_rvalid) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane datapath, computed from the captured request only.
    logic [ADDR_W-1:0]   addr0;
    logic [ADDR_W-1:0]   addr1;
    logic [3:0]          be_base;
    logic [7:0]          be8;
    logic [2*DATA_W-1:0] wd64;
    logic [DATA_W-1:0]   ld_word;
    logic [DATA_W-1:0]   ld_result;

    // Word addresses, byte-enable/data lane shifts and the load merge/extend.
    always_comb begin
        addr0 = {addr_q[ADDR_W-1:2], 2'b00};
        addr1 = addr0 + ADDR_W'(4);  // wraps from the top word to address 0
        case (type_q)
            T_H, T_HU: be_base = 4'b0011;
            T_W:       be_base = 4'b1111;
            default:   be_base = 4'b0001;
        endcase
        be8     = {4'b0000, be_base} << addr_q[1:0];
        wd64    = {{DATA_W{1'b0}}, wdata_q} << {addr_q[1:0], 3'b000};
        ld_word = DATA_W'({word1_q, word0_q} >> {addr_q[1:0], 3'b000});
        case (type_q)
            T_B:     ld_result = {{24{ld_word[7]}}, ld_word[7:0]};
            T_H:     ld_result = {{16{ld_word[15]}}, ld_word[15:0]};
            T_W:     ld_result = ld_word;
            T_BU:    ld_result = {24'h0, ld_word[7:0]};
            T_HU:    ld_result = {16'h0, ld_word[15:0]};
            default: ld_result = '0;
        endcase
    end

    // Outputs decoded from the state register and captured request.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can leave
        // one unassigned and infer a latch.
        req_ready  = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_be     = 4'b0000;
        mem_wdata  = '0;
        case (state_q)
            S_ACC0: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr0;
                mem_be    = be8[3:0];
                mem_wdata = we_q ? wd64[DATA_W-1:0] : '0;
            end
            S_ACC1: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr1;
                mem_be    = be8[7:4];
                mem_wdata = we_q ? wd64[2*DATA_W-1:DATA_W] : '0;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (err_q || we_q) ? '0 : ld_result;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// tb_mem_access_ctrl
// Scoreboard bench: a byte-level reference model predicts responses and memory
// transactions at issue time; a memory responder and a response monitor pop and
// compare whenever the DUT presents a transaction or a response.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_type = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; int lat; int acc_cyc; } resp_t;
    typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } txn_t;

    resp_t resp_q[$];
    txn_t  txn_q[$];

    // Memory responder knobs.
    bit gnt_rand = 1'b0;
    int gnt_wait_cfg = 0;
    int rv_cfg = 0;

    logic [31:0] dev_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_msg(string name, string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    function automatic logic [31:0] init_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] dev_read(logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic logic [7:0] ref_byte(logic [31:0] ba);
        logic [31:0] w;
        if (ref_mem.exists(ba)) return ref_mem[ba];
        w = init_word({ba[31:2], 2'b00});
        return w[8*int'(ba[1:0]) +: 8];
    endfunction

    task automatic preload(logic [31:0] a, logic [31:0] w);
        dev_mem[a] = w;
        for (int i = 0; i < 4; i++) ref_mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    // Reference model: treats memory as a byte array, walks the touched bytes and
    // groups them into the word transactions a single-port word memory needs.
    task automatic model(logic we, logic [2:0] ty, logic [31:0] a, logic [31:0] wd, bit timed);
        resp_t r;
        txn_t t0, t1;
        int size, lane;
        logic [31:0] ba, w0, val;
        bit two;
        r.acc_cyc = cyc + 1;
        r.lat = 0;
        if (we ? (ty > 3'd2) : (ty > 3'd4)) begin
            r.rdata = 32'h0;
            r.err = 1'b1;
            if (timed) r.lat = 1;
            resp_q.push_back(r);
            return;
        end
        size = (ty == 3'd2) ? 4 : ((ty == 3'd1 || ty == 3'd4) ? 2 : 1);
        w0 = a & ~32'd3;
        t0 = '{addr: w0, we: we, be: 4'b0000, wdata: 32'h0};
        t1 = '{addr: w0 + 32'd4, we: we, be: 4'b0000, wdata: 32'h0};
        two = 1'b0;
        val = 32'h0;
        for (int i = 0; i < size; i++) begin
            ba = a + 32'(i);
            lane = int'(ba[1:0]);
            if ((ba & ~32'd3) == w0) begin
                t0.be[lane] = 1'b1;
                t0.wdata[8*lane +: 8] = wd[8*i +: 8];
            end else begin
                two = 1'b1;
                t1.be[lane] = 1'b1;
                t1.wdata[8*lane +: 8] = wd[8*i +: 8];
            end
            if (we) ref_mem[ba] = wd[8*i +: 8];
            else    val[8*i +: 8] = ref_byte(ba);
        end
        if (ty == 3'd0) val = {{24{val[7]}}, val[7:0]};
        if (ty == 3'd1) val = {{16{val[15]}}, val[15:0]};
        r.rdata = we ? 32'h0 : val;
        r.err = 1'b0;
        if (timed) r.lat = we ? (two ? 3 : 2) : (two ? 5 : 3);
        txn_q.push_back(t0);
        if (two) txn_q.push_back(t1);
        resp_q.push_back(r);
    endtask

    // Present a request at a falling edge and hold it until accepted.
    task automatic issue(logic we, logic [2:0] ty, logic [31:0] a, logic [31:0] wd, bit timed);
        int budget;
        req_we = we;
        req_type = ty;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        budget = 0;
        while (!req_ready && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            fail_msg("accept_timeout", "req_ready never rose within 300 cycles");
            req_valid = 1'b0;
            return;
        end
        model(we, ty, a, wd, timed);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom);
        req_type = 3'($urandom);
        req_addr = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        int b = 0;
        while (resp_q.size() != 0 && b < 500) begin
            @(negedge clk);
            b++;
        end
        check("drain_resp_q", 32'(resp_q.size()), 32'h0);
    endtask

    // Memory responder: grants, checks each granted transaction against the
    // scoreboard, checks stability while stalled, and returns read data later.
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_be;
    logic        hold_we;
    bit          hold_vld = 1'b0;
    int          wait_cnt = 0;
    bit          rd_pend = 1'b0;
    int          rd_cnt = 0;
    logic [31:0] rd_addr;

    always @(negedge clk) begin
        txn_t t;
        logic [31:0] w;
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        if (rd_pend) begin
            if (rd_cnt == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata = dev_read(rd_addr);
                rd_pend = 1'b0;
            end else begin
                rd_cnt--;
            end
        end
        if (mem_req) begin
            if (hold_vld) begin
                check("stall_addr", mem_addr, hold_addr);
                check("stall_be", 32'(mem_be), 32'(hold_be));
                check("stall_we", 32'(mem_we), 32'(hold_we));
                check("stall_wdata", mem_wdata, hold_wdata);
            end
            if (wait_cnt < gnt_wait_cfg) begin
                mem_gnt = 1'b0;
                wait_cnt++;
            end else begin
                mem_gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
            if (mem_gnt) begin
                wait_cnt = 0;
                hold_vld = 1'b0;
                if (txn_q.size() == 0) begin
                    fail_msg("unexpected_txn", $sformatf("mem txn at 0x%08h, none expected", mem_addr));
                end else begin
                    t = txn_q.pop_front();
                    check("mem_addr", mem_addr, t.addr);
                    check("mem_we", 32'(mem_we), 32'(t.we));
                    check("mem_be", 32'(mem_be), 32'(t.be));
                    if (t.we) begin
                        for (int i = 0; i < 4; i++)
                            if (t.be[i]) check($sformatf("mem_wdata_lane%0d", i),
                                               32'(mem_wdata[8*i +: 8]), 32'(t.wdata[8*i +: 8]));
                    end
                end
                if (mem_we) begin
                    w = dev_read(mem_addr);
                    for (int i = 0; i < 4; i++)
                        if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
                    dev_mem[mem_addr] = w;
                end else begin
                    rd_pend = 1'b1;
                    rd_addr = mem_addr;
                    rd_cnt = (rv_cfg < 0) ? int'($urandom_range(0, 3)) : rv_cfg;
                end
            end else begin
                hold_vld = 1'b1;
                hold_addr = mem_addr;
                hold_be = mem_be;
                hold_we = mem_we;
                hold_wdata = mem_wdata;
            end
        end else begin
            if (hold_vld) fail_msg("req_dropped", "mem_req fell before mem_gnt");
            hold_vld = 1'b0;
            mem_gnt = gnt_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // Response monitor.
    int resp_seen = 0;
    always @(negedge clk) begin
        resp_t r;
        if (rst_n && resp_valid) begin
            resp_seen++;
            if (resp_q.size() == 0) begin
                fail_msg("unexpected_resp", $sformatf("resp_valid with rdata 0x%08h, none expected", resp_rdata));
            end else begin
                r = resp_q.pop_front();
                check("resp_rdata", resp_rdata, r.rdata);
                check("resp_err", 32'(resp_err), 32'(r.err));
                check("resp_busy", 32'(busy), 32'h1);
                check("resp_ready", 32'(req_ready), 32'h0);
                if (r.lat > 0) check("resp_latency", 32'(cyc + 1 - r.acc_cyc), 32'(r.lat));
            end
        end
    end

    task automatic check_reset_outputs(string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'h0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'h0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'h0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'h0);
        check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
        check({tag, "_mem_addr"}, mem_addr, 32'h0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen_before;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases with an ideal memory: gnt at once, rvalid one cycle later.
        gnt_rand = 1'b0; gnt_wait_cfg = 0; rv_cfg = 0;
        preload(32'h100, 32'hDEAD_BEEF);
        issue(1'b0, 3'b010, 32'h100, 32'h0, 1'b1);           // aligned LW
        drain();
        preload(32'h100, 32'h80FF_0000);
        issue(1'b0, 3'b000, 32'h103, 32'h0, 1'b1);           // LB
        issue(1'b0, 3'b011, 32'h103, 32'h0, 1'b1);           // LBU
        preload(32'h200, 32'h1122_3344);
        preload(32'h204, 32'hAABB_CC55);
        issue(1'b0, 3'b001, 32'h203, 32'h0, 1'b1);           // split LH
        issue(1'b1, 3'b010, 32'h301, 32'hA1B2_C3D4, 1'b1);   // split SW
        issue(1'b0, 3'b010, 32'h301, 32'h0, 1'b1);           // read it back, split LW
        issue(1'b1, 3'b001, 32'h013, 32'h0000_BEEF, 1'b1);   // split SH
        issue(1'b1, 3'b000, 32'h022, 32'h0000_0077, 1'b1);   // SB
        issue(1'b0, 3'b100, 32'h012, 32'h0, 1'b1);           // LHU
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0, 1'b1);     // split LW across wrap
        issue(1'b0, 3'b101, 32'h040, 32'h0, 1'b1);           // illegal load type
        issue(1'b1, 3'b011, 32'h040, 32'h1234_5678, 1'b1);   // illegal store type
        drain();

        // Stalled grant and late read data.
        gnt_wait_cfg = 5; rv_cfg = 3;
        issue(1'b0, 3'b010, 32'h041, 32'h0, 1'b0);
        drain();
        gnt_wait_cfg = 0;

        // Reset while waiting for read data; the late rvalid must be ignored.
        issue(1'b0, 3'b010, 32'h180, 32'h0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rstmid");
        resp_q.delete();
        txn_q.delete();
        seen_before = resp_seen;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("stray_rvalid_resp", 32'(resp_seen), 32'(seen_before));
        rv_cfg = 0;

        // Randomized traffic with a randomly stalling memory.
        gnt_rand = 1'b1; rv_cfg = -1;
        for (int n = 0; n < 300; n++) begin
            logic        r_we;
            logic [2:0]  r_ty;
            logic [31:0] r_a;
            r_we = 1'($urandom_range(0, 1));
            r_ty = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) r_a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           r_a = 32'($urandom_range(0, 63));
            issue(r_we, r_ty, r_a, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        check("drain_txn_q", 32'(txn_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
